// File: rtl/adder_defs.sv
// Shared definitions for the adder result stage: flag-vector layout and flag derivation.
package adder_defs;

    localparam int FLAGS_W = 4;
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;

    typedef logic [FLAGS_W-1:0] flags_t;

    // Signed overflow: operands agree in sign but the result sign differs from them.
    function automatic flags_t calc_flags(
        input logic sum_msb,
        input logic sum_zero,
        input logic carry,
        input logic a_msb,
        input logic b_msb
    );
        flags_t f;
        f         = '0;
        f[FLAG_N] = sum_msb;
        f[FLAG_Z] = sum_zero;
        f[FLAG_C] = carry;
        f[FLAG_V] = (a_msb == b_msb) && (sum_msb != a_msb);
        return f;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small register-based FIFO; head entry is read straight from the slot at the read pointer.
module result_fifo #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_req,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop_req,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = push_req && !full;
    assign pop   = pop_req && !empty;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (srst)
                    mem_reg[gi] <= '0;
                else if (push && (wr_ptr_reg == PTR_W'(gi)))
                    mem_reg[gi] <= wr_data;
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/adder_result_stage.sv
// Captures adder results with N/Z/C/V flags into a small FIFO toward writeback.
// Optional sticky {C,V} status is enabled by defining STICKY_FLAGS_EN.
module adder_result_stage
    import adder_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_sum,
    input  logic                       in_carry,
    input  logic                       in_a_msb,
    input  logic                       in_b_msb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic [FLAGS_W-1:0]         out_flags,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef STICKY_FLAGS_EN
    ,
    output logic [1:0]                 sticky_flags,
    input  logic                       sticky_clr
`endif
);

    localparam int ENTRY_W = WIDTH + FLAGS_W;

    flags_t             in_flags;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               full;
    logic               empty;

    assign in_flags = calc_flags(in_sum[WIDTH-1], (in_sum == '0), in_carry, in_a_msb, in_b_msb);
    assign wr_entry = {in_flags, in_sum};

    result_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .srst     (rst),
        .push_req (in_valid),
        .wr_data  (wr_entry),
        .pop_req  (out_ready),
        .rd_data  (rd_entry),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_sum   = rd_entry[WIDTH-1:0];
    assign out_flags = rd_entry[ENTRY_W-1:WIDTH];

`ifdef STICKY_FLAGS_EN
    logic       push;
    logic [1:0] sticky_reg;
    logic [1:0] sticky_next;

    assign push = in_valid && in_ready;

    // A bit set by this cycle's push overrides a simultaneous clear.
    always_comb begin
        sticky_next = sticky_clr ? 2'b00 : sticky_reg;
        if (push)
            sticky_next = sticky_next | {in_flags[FLAG_C], in_flags[FLAG_V]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            sticky_reg <= 2'b00;
        else
            sticky_reg <= sticky_next;
    end

    assign sticky_flags = sticky_reg;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed self-checking bench for adder_result_stage (DEPTH=2, WIDTH=16).
module tb_adder_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_carry;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [3:0]  out_flags;
    logic [1:0]  count;
`ifdef STICKY_FLAGS_EN
    logic [1:0]  sticky_flags;
    logic        sticky_clr;
`endif

    int checks;
    int errors;

    adder_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_carry     (in_carry),
        .in_a_msb     (in_a_msb),
        .in_b_msb     (in_b_msb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_flags    (out_flags),
        .count        (count)
`ifdef STICKY_FLAGS_EN
        ,
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic c,
                         input logic a, input logic b);
        in_valid = v;
        in_sum   = s;
        in_carry = c;
        in_a_msb = a;
        in_b_msb = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        if (out_sum !== 16'h0000) begin errors++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
        if (out_flags !== 4'b0000) begin errors++; $display("FAIL reset_out_flags got %b want 0000", out_flags); end
        $display("test_reset: valid=%b ready=%b count=%0d", out_valid, in_ready, count);
    endtask

    task automatic test_zero_flags();
        out_ready = 1'b0;
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_out_valid got %b want 1", out_valid); end
        if (out_flags !== 4'b0111) begin errors++; $display("FAIL zero_flags got %b want 0111", out_flags); end
        if (count !== 2'd1) begin errors++; $display("FAIL zero_count got %0d want 1", count); end
        $display("test_zero_flags: sum=%h flags=%b", out_sum, out_flags);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks += 1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_overflow_flags();
        drive(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (out_flags !== 4'b1001) begin errors++; $display("FAIL ovf_flags got %b want 1001", out_flags); end
        if (out_sum !== 16'h8000) begin errors++; $display("FAIL ovf_sum got %h want 8000", out_sum); end
        $display("test_overflow_flags: sum=%h flags=%b", out_sum, out_flags);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step();
        checks += 2;
        if (count !== 2'd1) begin errors++; $display("FAIL full_count1 got %0d want 1", count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %b want 1", in_ready); end
        drive(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        step();
        checks += 2;
        if (count !== 2'd2) begin errors++; $display("FAIL full_count2 got %0d want 2", count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready2 got %b want 0", in_ready); end
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        step();
        checks += 3;
        if (count !== 2'd2) begin errors++; $display("FAIL full_reject_count got %0d want 2", count); end
        if (out_sum !== 16'h1234) begin errors++; $display("FAIL full_head0 got %h want 1234", out_sum); end
        if (out_flags !== 4'b0000) begin errors++; $display("FAIL full_flags0 got %b want 0000", out_flags); end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        checks += 4;
        if (count !== 2'd1) begin errors++; $display("FAIL drain_count1 got %0d want 1", count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", in_ready); end
        if (out_sum !== 16'hFFFF) begin errors++; $display("FAIL drain_head1 got %h want ffff", out_sum); end
        if (out_flags !== 4'b1000) begin errors++; $display("FAIL drain_flags1 got %b want 1000", out_flags); end
        step();
        checks += 2;
        if (count !== 2'd0) begin errors++; $display("FAIL drain_count0 got %0d want 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
        $display("test_full: drained, count=%0d", count);
    endtask

    task automatic test_back_to_back();
        logic [15:0] val;
        out_ready = 1'b0;
        drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        step();
        // Full: this push is refused while the head is popped.
        drive(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        checks += 2;
        if (count !== 2'd1) begin errors++; $display("FAIL b2b_full_pop_count got %0d want 1", count); end
        if (out_sum !== 16'h0022) begin errors++; $display("FAIL b2b_full_pop_head got %h want 0022", out_sum); end
        for (int i = 0; i < 8; i++) begin
            val = 16'h0033 + 16'(i) * 16'h0011;
            drive(1'b1, val, 1'b0, 1'b0, 1'b0);
            step();
            checks += 2;
            if (count !== 2'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 1", i, count); end
            if (out_sum !== val) begin errors++; $display("FAIL b2b_head[%0d] got %h want %h", i, out_sum, val); end
            $display("test_back_to_back[%0d]: pushed=%h head=%h count=%0d", i, val, out_sum, count);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        checks += 1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        checks += 1;
        if (count !== 2'd2) begin errors++; $display("FAIL mid_count_pre got %0d want 2", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 4;
        if (count !== 2'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", in_ready); end
        if (out_sum !== 16'h0000) begin errors++; $display("FAIL mid_sum got %h want 0000", out_sum); end
        $display("test_reset_midstream: count=%0d valid=%b", count, out_valid);
    endtask

`ifdef STICKY_FLAGS_EN
    task automatic test_sticky();
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        checks += 1;
        if (sticky_flags !== 2'b00) begin errors++; $display("FAIL sticky_init got %b want 00", sticky_flags); end
        drive(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        step();
        checks += 1;
        if (sticky_flags !== 2'b01) begin errors++; $display("FAIL sticky_v got %b want 01", sticky_flags); end
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        sticky_clr = 1'b1;
        step();
        checks += 1;
        if (sticky_flags !== 2'b10) begin errors++; $display("FAIL sticky_clr_set got %b want 10", sticky_flags); end
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        sticky_clr = 1'b0;
        checks += 1;
        if (sticky_flags !== 2'b00) begin errors++; $display("FAIL sticky_clr got %b want 00", sticky_flags); end
        $display("test_sticky: sticky=%b", sticky_flags);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        test_reset();
        test_zero_flags();
        test_overflow_flags();
        test_full();
        test_back_to_back();
        test_reset_midstream();
`ifdef STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
